// File: rtl/spi_flash_pkg.sv
// Shared FSM state encodings, serial-flash opcodes and default geometry
// for the flash read sequencer.
package spi_flash_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CMD   = 3'd1;
  localparam logic [2:0] ST_ADDR  = 3'd2;
  localparam logic [2:0] ST_DUMMY = 3'd3;
  localparam logic [2:0] ST_DATA  = 3'd4;
  localparam logic [2:0] ST_END   = 3'd5;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam logic [7:0] OP_RDSR      = 8'h05;

  localparam int DEF_ADDR_W = 24;
  localparam int DEF_LEN_W  = 16;
  localparam int DEF_CS_GAP = 4;

endpackage

// File: rtl/spi_flash_reader_handshake.sv
// Byte-engine handshake: issues one start at a time and reports the received
// byte on the first cycle busy is low after having been seen high.
module spi_byte_handshake (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_send,
  input  logic [7:0] i_tx_data,
  output logic       o_ready,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_data,
  output logic       o_byte_start,
  output logic [7:0] o_byte_data,
  input  logic       i_byte_busy,
  input  logic [7:0] i_byte_data
);

  logic       r_start;
  logic       r_outstanding;
  logic       r_seen_busy;
  logic [7:0] r_tx;
  logic       w_fire;
  logic       w_done;

  assign o_ready      = ~r_outstanding & ~i_byte_busy;
  assign w_fire       = i_send & o_ready;
  assign w_done       = r_outstanding & r_seen_busy & ~i_byte_busy;
  assign o_rx_valid   = w_done;
  assign o_rx_data    = i_byte_data;
  assign o_byte_start = r_start;
  assign o_byte_data  = r_tx;

  // Busy-fall only counts once busy was observed for the byte we launched.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_start       <= 1'b0;
      r_tx          <= 8'h00;
      r_outstanding <= 1'b0;
      r_seen_busy   <= 1'b0;
    end else begin
      r_start <= w_fire;
      if (w_fire) begin
        r_tx          <= i_tx_data;
        r_outstanding <= 1'b1;
      end
      if (r_outstanding && i_byte_busy)
        r_seen_busy <= 1'b1;
      if (w_done) begin
        r_outstanding <= 1'b0;
        r_seen_busy   <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/spi_flash_reader.sv
// Serial-flash READ sequencer: drives chip-select and the byte engine through
// command, address, dummy and data phases, streaming data bytes out.
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter logic [7:0] CMD_READ    = OP_READ,
  parameter int         ADDR_W      = DEF_ADDR_W,
  parameter int         LEN_W       = DEF_LEN_W,
  parameter int         DUMMY_BYTES = 0,
  parameter int         CS_GAP      = DEF_CS_GAP
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [LEN_W-1:0]  req_len_i,
  output logic [7:0]        rd_data_o,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic              done_o,
  output logic              cs_n_o,
  output logic              byte_start_o,
  output logic [7:0]        byte_data_o,
  input  logic              byte_busy_i,
  input  logic [7:0]        byte_data_i
);

  localparam int ADDR_BYTES = ADDR_W / 8;
  localparam int GAP_W      = $clog2(CS_GAP + 1);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_remain;
  logic [7:0]        r_idx;
  logic [GAP_W-1:0]  r_gap;
  logic              r_cs_n;
  logic              r_done;
  logic              r_rd_valid;
  logic [7:0]        r_rd_data;

  logic              w_gap_done;
  logic              w_send;
  logic [7:0]        w_tx;
  logic              w_hs_ready;
  logic              w_rx_valid;
  logic [7:0]        w_rx_data;
  logic              w_rd_hs;

  assign w_gap_done  = (r_gap == '0);
  assign w_rd_hs     = r_rd_valid & rd_ready_i;
  assign req_ready_o = (r_state == ST_IDLE) & w_gap_done & ~byte_busy_i;
  assign cs_n_o      = r_cs_n;
  assign done_o      = r_done;
  assign rd_valid_o  = r_rd_valid;
  assign rd_data_o   = r_rd_data;

  // Data phase holds off the next byte while the stream is stalled.
  always_comb begin
    w_send = 1'b0;
    w_tx   = 8'h00;
    case (r_state)
      ST_CMD: begin
        w_send = 1'b1;
        w_tx   = CMD_READ;
      end
      ST_ADDR: begin
        w_send = 1'b1;
        w_tx   = r_addr[ADDR_W-1 -: 8];
      end
      ST_DUMMY: w_send = 1'b1;
      ST_DATA:  w_send = (r_remain != '0) & ~(r_rd_valid & ~rd_ready_i);
      default:  w_send = 1'b0;
    endcase
  end

  spi_byte_handshake u_hs (
    .i_clk        (clk_i),
    .i_rst_n      (rst_n_i),
    .i_send       (w_send),
    .i_tx_data    (w_tx),
    .o_ready      (w_hs_ready),
    .o_rx_valid   (w_rx_valid),
    .o_rx_data    (w_rx_data),
    .o_byte_start (byte_start_o),
    .o_byte_data  (byte_data_o),
    .i_byte_busy  (byte_busy_i),
    .i_byte_data  (byte_data_i)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state    <= ST_IDLE;
      r_cs_n     <= 1'b1;
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= 8'h00;
      r_idx      <= 8'd0;
      r_gap      <= GAP_W'(CS_GAP);
    end else begin
      r_done <= 1'b0;
      if (!w_gap_done)
        r_gap <= r_gap - GAP_W'(1);
      if (w_rd_hs)
        r_rd_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid_i && req_ready_o) begin
            r_addr   <= req_addr_i;
            r_remain <= req_len_i;
            r_idx    <= 8'd0;
            if (req_len_i == '0) begin
              r_done <= 1'b1;
              r_gap  <= GAP_W'(CS_GAP);
            end else begin
              r_cs_n  <= 1'b0;
              r_state <= ST_CMD;
            end
          end
        end
        ST_CMD: begin
          if (w_rx_valid)
            r_state <= ST_ADDR;
        end
        ST_ADDR: begin
          if (w_rx_valid) begin
            r_addr <= r_addr << 8;
            if (r_idx == 8'(ADDR_BYTES - 1)) begin
              r_idx   <= 8'd0;
              r_state <= (DUMMY_BYTES > 0) ? ST_DUMMY : ST_DATA;
            end else begin
              r_idx <= r_idx + 8'd1;
            end
          end
        end
        ST_DUMMY: begin
          if (w_rx_valid) begin
            if (r_idx == 8'(DUMMY_BYTES - 1)) begin
              r_idx   <= 8'd0;
              r_state <= ST_DATA;
            end else begin
              r_idx <= r_idx + 8'd1;
            end
          end
        end
        ST_DATA: begin
          if (w_rx_valid && (r_remain != '0)) begin
            r_rd_data  <= w_rx_data;
            r_rd_valid <= 1'b1;
            r_remain   <= r_remain - LEN_W'(1);
          end
          // A zero count here means the byte being handshaken is the last one.
          if (w_rd_hs && (r_remain == '0))
            r_state <= ST_END;
        end
        ST_END: begin
          r_cs_n  <= 1'b1;
          r_done  <= 1'b1;
          r_gap   <= GAP_W'(CS_GAP);
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader with a behavioural byte-engine model
// and expected-byte queues for MOSI and the read stream.
module tb_spi_flash_reader;

  localparam int BYTE_CYC = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, req_valid, rd_ready;
  logic [23:0] req_addr;
  logic [15:0] req_len;
  logic        req_ready, rd_valid, done, cs_n, bstart, bbusy;
  logic [7:0]  rd_data, bdata;
  logic [7:0]  bdin = 8'h00;
  logic        r_bbusy = 1'b0;
  int          bcnt = 0;
  logic [7:0]  miso_q[$];

  logic        d_req_valid, d_rd_ready;
  logic [23:0] d_req_addr;
  logic [15:0] d_req_len;
  logic        d_req_ready, d_rd_valid, d_done, d_cs_n, d_bstart, d_bbusy;
  logic [7:0]  d_rd_data, d_bdata;
  logic [7:0]  d_bdin = 8'h00;
  logic        d_r_bbusy = 1'b0;
  int          d_bcnt = 0;
  logic [7:0]  d_miso_q[$];

  int n_vec = 0, n_err = 0;
  int n_starts = 0, n_done = 0, n_cs_fall = 0, hi_run = 0, last_hi = 0;
  logic prev_cs = 1'b1;
  logic [7:0] exp_mosi[$], exp_rd[$];
  logic [7:0] d_mosi_log[$], d_rd_log[$];
  int d_done_cnt = 0;

  spi_flash_reader dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_len_i(req_len), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .rd_ready_i(rd_ready), .done_o(done), .cs_n_o(cs_n), .byte_start_o(bstart),
    .byte_data_o(bdata), .byte_busy_i(bbusy), .byte_data_i(bdin)
  );

  spi_flash_reader #(.DUMMY_BYTES(1)) dut_d (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(d_req_valid), .req_ready_o(d_req_ready),
    .req_addr_i(d_req_addr), .req_len_i(d_req_len), .rd_data_o(d_rd_data), .rd_valid_o(d_rd_valid),
    .rd_ready_i(d_rd_ready), .done_o(d_done), .cs_n_o(d_cs_n), .byte_start_o(d_bstart),
    .byte_data_o(d_bdata), .byte_busy_i(d_bbusy), .byte_data_i(d_bdin)
  );

  // Byte engine models: busy rises with start, rx byte appears as busy falls.
  assign bbusy   = bstart | r_bbusy;
  assign d_bbusy = d_bstart | d_r_bbusy;

  always @(posedge clk) begin
    if (bstart) begin
      r_bbusy <= 1'b1;
      bcnt    <= BYTE_CYC;
    end else if (r_bbusy) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) begin
        r_bbusy <= 1'b0;
        if (miso_q.size() != 0) bdin <= miso_q.pop_front();
        else bdin <= 8'hEE;
      end
    end
  end

  always @(posedge clk) begin
    if (d_bstart) begin
      d_r_bbusy <= 1'b1;
      d_bcnt    <= BYTE_CYC;
    end else if (d_r_bbusy) begin
      d_bcnt <= d_bcnt - 1;
      if (d_bcnt == 1) begin
        d_r_bbusy <= 1'b0;
        if (d_miso_q.size() != 0) d_bdin <= d_miso_q.pop_front();
        else d_bdin <= 8'hEE;
      end
    end
  end

  task automatic chk(input string tag, input int got, input int expv);
    n_vec++;
    assert (got === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, expv);
    end
  endtask

  always @(negedge clk) begin
    logic has;
    if (bstart) begin
      n_starts++;
      has = (exp_mosi.size() != 0);
      chk("mosi_expected", int'(has), 1);
      if (has) chk("mosi", int'(bdata), int'(exp_mosi.pop_front()));
    end
    if (rd_valid && rd_ready) begin
      has = (exp_rd.size() != 0);
      chk("rd_expected", int'(has), 1);
      if (has) chk("rd_data", int'(rd_data), int'(exp_rd.pop_front()));
    end
    if (done) n_done++;
    if (cs_n) hi_run++;
    else begin
      if (prev_cs) begin
        n_cs_fall++;
        last_hi = hi_run;
      end
      hi_run = 0;
    end
    prev_cs = cs_n;
  end

  always @(negedge clk) begin
    if (d_bstart) d_mosi_log.push_back(d_bdata);
    if (d_rd_valid && d_rd_ready) d_rd_log.push_back(d_rd_data);
    if (d_done) d_done_cnt++;
  end

  task automatic do_req(input logic [23:0] a, input logic [15:0] l);
    int cyc = 0;
    @(negedge clk);
    while (!req_ready && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk("req_ready_wait", int'(req_ready), 1);
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int cyc = 0;
    @(negedge clk);
    while (!done && cyc < 600) begin
      @(negedge clk);
      cyc++;
    end
    chk(tag, int'(done), 1);
  endtask

  task automatic push_junk(input int n);
    for (int i = 0; i < n; i++) miso_q.push_back(8'h11 + 8'(i));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, b_done, b_fall, b_start;
    logic quiet;
    logic [7:0] d_exp [7] = '{8'h03, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00};

    rst_n = 1'b0; req_valid = 1'b0; rd_ready = 1'b0; req_addr = '0; req_len = '0;
    d_req_valid = 1'b0; d_rd_ready = 1'b1; d_req_addr = '0; d_req_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs_n", int'(cs_n), 1);
    chk("rst_start", int'(bstart), 0);
    chk("rst_bdata", int'(bdata), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_req_ready", int'(req_ready), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (!req_ready && cyc < 50) begin
      cyc++;
      @(negedge clk);
    end
    chk("rst_gap_honoured", int'(cyc >= 4), 1);

    // Basic read of three bytes
    @(posedge clk); #1 rd_ready = 1'b1;
    miso_q.delete(); push_junk(4);
    miso_q.push_back(8'hA5); miso_q.push_back(8'h5A); miso_q.push_back(8'hFF);
    exp_mosi = '{8'h03, 8'h01, 8'h23, 8'h45, 8'h00, 8'h00, 8'h00};
    exp_rd   = '{8'hA5, 8'h5A, 8'hFF};
    b_done = n_done; b_fall = n_cs_fall;
    do_req(24'h012345, 16'd3);
    wait_done("t1_done");
    chk("t1_cs_high_at_done", int'(cs_n), 1);
    @(negedge clk);
    chk("t1_done_pulse", int'(done), 0);
    chk("t1_mosi_left", exp_mosi.size(), 0);
    chk("t1_rd_left", exp_rd.size(), 0);
    chk("t1_cs_windows", n_cs_fall - b_fall, 1);
    chk("t1_done_count", n_done - b_done, 1);

    // Zero-length request
    b_fall = n_cs_fall; b_start = n_starts;
    do_req(24'h000777, 16'd0);
    @(negedge clk);
    chk("t2_done", int'(done), 1);
    @(negedge clk);
    chk("t2_done_pulse", int'(done), 0);
    repeat (3) @(negedge clk);
    chk("t2_no_cs", n_cs_fall - b_fall, 0);
    chk("t2_no_start", n_starts - b_start, 0);

    // Stream back-pressure with byte 2 held
    @(posedge clk); #1 rd_ready = 1'b0;
    miso_q.delete(); push_junk(4);
    miso_q.push_back(8'h31); miso_q.push_back(8'h32); miso_q.push_back(8'h33); miso_q.push_back(8'h34);
    exp_mosi = '{8'h03, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_rd   = '{8'h31, 8'h32, 8'h33, 8'h34};
    b_done = n_done;
    do_req(24'h000040, 16'd4);
    cyc = 0;
    @(negedge clk);
    while (!rd_valid && cyc < 300) begin @(negedge clk); cyc++; end
    chk("t3_byte1_valid", int'(rd_valid), 1);
    @(posedge clk); #1 rd_ready = 1'b1;
    @(posedge clk); #1 rd_ready = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (!rd_valid && cyc < 300) begin @(negedge clk); cyc++; end
    chk("t3_byte2_data", int'(rd_data), 8'h32);
    b_start = n_starts;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t3_stall_valid", int'(rd_valid), 1);
      chk("t3_stall_data", int'(rd_data), 8'h32);
      chk("t3_stall_cs", int'(cs_n), 0);
    end
    @(negedge clk);
    chk("t3_stall_no_start", n_starts - b_start, 0);
    @(posedge clk); #1 rd_ready = 1'b1;
    wait_done("t3_done");
    @(negedge clk);
    chk("t3_mosi_left", exp_mosi.size(), 0);
    chk("t3_rd_left", exp_rd.size(), 0);
    chk("t3_done_count", n_done - b_done, 1);

    // Back-to-back requests
    miso_q.delete();
    push_junk(4); miso_q.push_back(8'hB1);
    push_junk(4); miso_q.push_back(8'hB2);
    exp_mosi = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'h10, 8'h00, 8'h00, 8'h00};
    exp_rd   = '{8'hB1, 8'hB2};
    do_req(24'h000000, 16'd1);
    wait_done("t4_done_a");
    do_req(24'h100000, 16'd1);
    wait_done("t4_done_b");
    @(negedge clk);
    chk("t4_cs_gap", int'(last_hi >= 4), 1);
    chk("t4_mosi_left", exp_mosi.size(), 0);
    chk("t4_rd_left", exp_rd.size(), 0);

    // One dummy byte variant
    d_miso_q.delete();
    for (int i = 0; i < 4; i++) d_miso_q.push_back(8'h60 + 8'(i));
    d_miso_q.push_back(8'h99); d_miso_q.push_back(8'hC1); d_miso_q.push_back(8'hC2);
    d_mosi_log.delete(); d_rd_log.delete();
    b_done = d_done_cnt;
    cyc = 0;
    @(negedge clk);
    while (!d_req_ready && cyc < 300) begin @(negedge clk); cyc++; end
    chk("t5_req_ready", int'(d_req_ready), 1);
    d_req_valid = 1'b1; d_req_addr = 24'h000010; d_req_len = 16'd2;
    @(posedge clk); #1 d_req_valid = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (!d_done && cyc < 600) begin @(negedge clk); cyc++; end
    chk("t5_done", int'(d_done), 1);
    @(negedge clk);
    chk("t5_mosi_count", d_mosi_log.size(), 7);
    for (int i = 0; i < 7; i++)
      if (i < d_mosi_log.size()) chk("t5_mosi", int'(d_mosi_log[i]), int'(d_exp[i]));
    chk("t5_rd_count", d_rd_log.size(), 2);
    if (d_rd_log.size() == 2) begin
      chk("t5_rd0", int'(d_rd_log[0]), 8'hC1);
      chk("t5_rd1", int'(d_rd_log[1]), 8'hC2);
    end
    chk("t5_done_count", d_done_cnt - b_done, 1);

    // Reset during the second address byte
    miso_q.delete();
    exp_mosi = '{8'h03, 8'h01, 8'h23};
    exp_rd.delete();
    b_done = n_done; b_start = n_starts;
    do_req(24'h012345, 16'd3);
    cyc = 0;
    @(negedge clk);
    while ((n_starts - b_start) < 3 && cyc < 300) begin @(negedge clk); cyc++; end
    chk("t6_busy_before_rst", int'(bbusy), 1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_cs_n", int'(cs_n), 1);
    chk("t6_rd_valid", int'(rd_valid), 0);
    chk("t6_done", int'(done), 0);
    chk("t6_start", int'(bstart), 0);
    chk("t6_req_ready", int'(req_ready), 0);
    cyc = 1;
    quiet = 1'b1;
    while (cyc < 300) begin
      @(negedge clk);
      if (req_ready) break;
      if (rd_valid || done || !cs_n) quiet = 1'b0;
      cyc++;
    end
    chk("t6_ready_after_busy", int'(bbusy), 0);
    chk("t6_ready_after_gap", int'(cyc >= 4), 1);
    chk("t6_quiet", int'(quiet), 1);
    chk("t6_no_done", n_done - b_done, 0);
    chk("t6_mosi_left", exp_mosi.size(), 0);
    miso_q.delete(); push_junk(4); miso_q.push_back(8'h7E);
    exp_mosi = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_rd   = '{8'h7E};
    do_req(24'h000000, 16'd1);
    wait_done("t6_recover_done");
    @(negedge clk);
    chk("t6_recover_mosi_left", exp_mosi.size(), 0);
    chk("t6_recover_rd_left", exp_rd.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
